// File: rtl/delay_playback.sv
// Circular-RAM delay line: samples written one per cycle are replayed after a
// programmable delay through a valid/ready output stage that the sink may stall.
module delay_playback #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic [A_WIDTH-1:0] delay,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] out_data,
    output logic               primed,
    output logic               overrun
);

    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] FULL = {1'b1, {A_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [D_WIDTH-1:0]   mem [DEPTH];
    logic [A_WIDTH-1:0]   wr_ptr;
    logic [A_WIDTH-1:0]   rd_ptr;
    logic [A_WIDTH-1:0]   d_reg;
    logic [A_WIDTH:0]     level;
    logic                 wr_en;
    logic                 fetch;
    logic                 full_wr;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = PRIME;
            PRIME:   if (level >= {1'b0, d_reg}) state_nxt = STREAM;
            STREAM:  state_nxt = STREAM;
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    assign wr_en   = in_valid && (state != IDLE);
    assign fetch   = en && (state == STREAM) && (level != '0) && (!out_valid || out_ready);
    // A write into a full buffer with no concurrent fetch sacrifices the oldest sample.
    assign full_wr = wr_en && !fetch && (level == FULL);
    assign primed  = (state == STREAM);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            if (rst) d_reg <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) d_reg <= (delay == '0) ? A_WIDTH'(1) : delay;
            if (wr_en) wr_ptr <= wr_ptr + A_WIDTH'(1);
            if (fetch || full_wr) rd_ptr <= rd_ptr + A_WIDTH'(1);
            if (wr_en && !fetch && !full_wr) level <= level + (A_WIDTH+1)'(1);
            else if (fetch && !wr_en) level <= level - (A_WIDTH+1)'(1);
            if (full_wr) overrun <= 1'b1;
            if (fetch) out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
        end
    end

    // Sample storage and read stage; the RAM itself is never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) out_data <= '0;
        else if (fetch) out_data <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_delay_playback.sv
// Directed bench for delay_playback (8-deep buffer): stimulus queues expected
// samples, a monitor pops and compares them on every output handshake.
module tb_delay_playback;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [AW-1:0] delay;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          primed;
    logic          overrun;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp;
    logic [DW-1:0] d;

    always #5 clk = ~clk;

    delay_playback #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .delay     (delay),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .primed    (primed),
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, return at the falling edge.
    task automatic cyc(input logic e, input logic iv, input logic [DW-1:0] dat,
                       input logic r, input logic [AW-1:0] dl, input logic push);
        @(posedge clk);
        #1;
        en = e; in_valid = iv; in_data = dat; out_ready = r; delay = dl;
        if (push) exp_q.push_back(dat);
        @(negedge clk);
    endtask

    task automatic drain(input string name, input logic [AW-1:0] dl);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            cyc(1'b1, 1'b0, '0, 1'b1, dl, 1'b0);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        cyc(1'b1, 1'b0, '0, 1'b1, dl, 1'b0);
        check({name, "_valid_low_after_drain"}, out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data_stream", out_data, mon_exp);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; delay = '0;
        repeat (2) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_primed", primed, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Basic delay of 4
        cyc(1'b1, 1'b0, '0, 1'b1, 3'd4, 1'b0);
        for (int n = 0; n < 16; n++) begin
            cyc(1'b1, 1'b1, 8'(16 + n), 1'b1, 3'd4, 1'b1);
            if (n == 4) check("t1_primed_c4", primed, 0);
            if (n == 5) begin
                check("t1_primed_c5", primed, 1);
                check("t1_valid_c5", out_valid, 0);
            end
            if (n == 6) begin
                check("t1_valid_c6", out_valid, 1);
                check("t1_data_c6", out_data, 8'h10);
            end
        end
        drain("t1", 3'd4);

        // Zero delay treated as one; later delay changes ignored
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd4, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1, 3'd0, 1'b0);
        check("t2_idle_primed", primed, 0);
        for (int n = 0; n < 18; n++) begin
            cyc(1'b1, 1'b1, 8'(64 + n), !(n >= 10 && n < 15), (n == 0) ? 3'd0 : 3'd7, 1'b1);
            if (n == 1) check("t2_primed_c1", primed, 0);
            if (n == 2) begin
                check("t2_primed_c2", primed, 1);
                check("t2_valid_c2", out_valid, 0);
            end
            if (n == 3) begin
                check("t2_valid_c3", out_valid, 1);
                check("t2_data_c3", out_data, 8'h40);
            end
            // Stall: held sample must stay put
            if (n >= 10 && n < 15) begin
                check("t3_stall_valid", out_valid, 1);
                check("t3_stall_data", out_data, 8'h47);
            end
        end
        check("t3_no_overrun", overrun, 0);
        drain("t3", 3'd7);

        // Overrun with delay 7 and stalled sink
        cyc(1'b0, 1'b0, '0, 1'b0, 3'd7, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 3'd7, 1'b0);
        for (int n = 0; n < 18; n++) begin
            cyc(1'b1, 1'b1, 8'(128 + n), 1'b0, 3'd7, (n == 0 || n >= 10));
            if (n == 7) check("t4_primed_c7", primed, 0);
            if (n == 8) check("t4_primed_c8", primed, 1);
            if (n == 9) begin
                check("t4_valid_c9", out_valid, 1);
                check("t4_data_c9", out_data, 8'h80);
                check("t4_overrun_c9", overrun, 0);
            end
            if (n == 10) check("t4_overrun_c10", overrun, 1);
        end
        drain("t4", 3'd7);
        check("t4_overrun_sticky", overrun, 1);

        // En dropped mid-stream with a stalled sample pending
        for (int n = 0; n < 3; n++) cyc(1'b1, 1'b1, 8'hEE, 1'b0, 3'd7, 1'b0);
        check("t5_pending_valid", out_valid, 1);
        cyc(1'b0, 1'b0, '0, 1'b0, 3'd2, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1, 3'd2, 1'b0);
        check("t5_idle_valid", out_valid, 0);
        check("t5_idle_overrun", overrun, 0);
        check("t5_idle_primed", primed, 0);
        for (int n = 0; n < 8; n++) begin
            cyc(1'b1, 1'b1, 8'(160 + n), 1'b1, 3'd2, 1'b1);
            if (n == 3) check("t5_valid_c3", out_valid, 0);
            if (n == 4) begin
                check("t5_valid_c4", out_valid, 1);
                check("t5_data_c4", out_data, 8'hA0);
            end
        end
        drain("t5", 3'd2);

        // Input gap in STREAM with delay 3
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd3, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1, 3'd3, 1'b0);
        for (int n = 0; n < 24; n++) begin
            d = (n < 10) ? 8'(192 + n) : 8'(208 + n - 20);
            cyc(1'b1, (n < 10 || n >= 20), d, 1'b1, 3'd3, (n < 10 || n >= 20));
            if (n == 4) check("t6_primed_c4", primed, 1);
            if (n == 5) check("t6_data_c5", out_data, 8'hC0);
            if (n == 14) check("t6_valid_c14", out_valid, 1);
            if (n == 15) check("t6_valid_c15", out_valid, 0);
            if (n == 19) begin
                check("t6_valid_c19", out_valid, 0);
                check("t6_primed_c19", primed, 1);
            end
            if (n == 21) check("t6_valid_c21", out_valid, 0);
            if (n == 22) begin
                check("t6_valid_c22", out_valid, 1);
                check("t6_data_c22", out_data, 8'hD0);
            end
        end
        drain("t6", 3'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
